bcd_converter_param: RTL and testbench

Parametrised sequential binary-to-BCD converter using the shift-add-3 (double-dabble) algorithm. Binary width and BCD digit count are parameters. It uses an explicit start/busy/done handshake. It also outputs a leading-zero blanking mask and an overflow flag with saturation. It sits between counter/measurement logic and the seven-segment scan/decoder path.

---
 rtl/bcd_pkg.sv | 23 ++
 rtl/bcd_add3_digit.sv | 9 +
 rtl/bcd_converter_param.sv | 120 ++++++++++++
 tb/tb_bcd_converter_param.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } bcd_state_e;

    localparam logic [3:0] BCD_NINE = 4'd9;

    // Ceiling log2, with clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction cell: a nibble above 4 gets +3 before the next shift.
module bcd_add3_digit (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din > 4'd4) ? din + 4'd3 : din;

endmodule

// File: rtl/bcd_converter_param.sv
// Sequential shift-add-3 binary-to-BCD converter with leading-zero blanking
// mask and saturating overflow.
module bcd_converter_param
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 12,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     blank_mask,
    output logic                  overflow
);

    localparam int SCR_W = 4 * DIGITS + BIN_W;
    localparam int CNT_W = clog2(BIN_W) + 1;
    localparam logic [DIGITS-1:0] MASK_RST = {DIGITS{1'b1}} << 1;

    // Handshake: start is sampled only in IDLE; busy is high from the capture
    // edge until done; done pulses for one cycle (the first IDLE cycle) and a
    // start in that cycle is accepted. Starts while busy are dropped.

    bcd_state_e           state_q, state_d;
    logic [SCR_W-1:0]     scratch_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 ovf_acc_q;
    logic [4*DIGITS-1:0]  add3_bcd;
    logic [4*DIGITS-1:0]  bcd_d;
    logic [DIGITS-1:0]    mask_d;
    logic                 last_shift;

    assign last_shift = (cnt_q == CNT_W'(BIN_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ADD;
            ADD:     state_d = SHIFT;
            SHIFT:   state_d = last_shift ? DONE : ADD;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_add3
            bcd_add3_digit u_add3 (
                .din  (scratch_q[BIN_W + 4*gi +: 4]),
                .dout (add3_bcd[4*gi +: 4])
            );
        end
    endgenerate

    // Saturate to all nines when any bit fell off the top of the BCD field.
    assign bcd_d = ovf_acc_q ? {DIGITS{BCD_NINE}} : scratch_q[SCR_W-1:BIN_W];

    // Digit i blanks when it and every digit above it are zero; digit 0 never blanks.
    assign mask_d[0] = 1'b0;
    generate
        for (gi = 1; gi < DIGITS; gi++) begin : g_mask
            assign mask_d[gi] = ((bcd_d >> (4*gi)) == '0);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_acc_q  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bcd_out    <= '0;
            blank_mask <= MASK_RST;
            overflow   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        scratch_q <= {{(4*DIGITS){1'b0}}, bin_in};
                        cnt_q     <= '0;
                        ovf_acc_q <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                ADD: begin
                    scratch_q <= {add3_bcd, scratch_q[BIN_W-1:0]};
                end
                SHIFT: begin
                    scratch_q <= {scratch_q[SCR_W-2:0], 1'b0};
                    ovf_acc_q <= ovf_acc_q | scratch_q[SCR_W-1];
                    cnt_q     <= cnt_q + CNT_W'(1);
                end
                DONE: begin
                    bcd_out    <= bcd_d;
                    blank_mask <= mask_d;
                    overflow   <= ovf_acc_q;
                    done       <= 1'b1;
                    busy       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_converter_param.sv
// Scoreboard bench for bcd_converter_param: a 4-digit and a 3-digit instance.
module tb_bcd_converter_param;

    localparam int BIN_W = 12;
    localparam int LAT   = 2 * BIN_W + 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start3;
    logic [11:0] bin_in, bin_in3;
    logic        busy, done, overflow;
    logic [15:0] bcd_out;
    logic [3:0]  blank_mask;
    logic        busy3, done3, overflow3;
    logic [11:0] bcd_out3;
    logic [2:0]  blank_mask3;

    bcd_converter_param #(.BIN_W(BIN_W), .DIGITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
        .busy(busy), .done(done), .bcd_out(bcd_out),
        .blank_mask(blank_mask), .overflow(overflow)
    );

    bcd_converter_param #(.BIN_W(BIN_W), .DIGITS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .bin_in(bin_in3),
        .busy(busy3), .done(done3), .bcd_out(bcd_out3),
        .blank_mask(blank_mask3), .overflow(overflow3)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state
    int total = 0;
    int bad   = 0;
    logic [20:0] exp_q[$];   // {bcd[15:0], mask[3:0], ovf}
    logic [15:0] exp3_q[$];  // {bcd[11:0], mask[2:0], ovf}
    int          cap_q[$];
    int          cap3_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: 4-digit instance
    logic prev_done = 1'b0;
    always @(negedge clk) begin : mon4
        logic [20:0] e;
        int c;
        if (done === 1'b1) begin
            check("done_one_cycle", prev_done, 0);
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending conversion (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                c = cap_q.pop_front();
                check("bcd_out",      bcd_out,    e[20:5]);
                check("blank_mask",   blank_mask, e[4:1]);
                check("overflow",     overflow,   e[0]);
                check("latency",      cyc - c,    LAT);
                check("busy_at_done", busy,       0);
            end
        end
        prev_done = (done === 1'b1);
    end

    // monitor: 3-digit instance
    logic prev_done3 = 1'b0;
    always @(negedge clk) begin : mon3
        logic [15:0] e;
        int c;
        if (done3 === 1'b1) begin
            check("done3_one_cycle", prev_done3, 0);
            if (exp3_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_done3: got done=1 expected no pending conversion (cycle %0d)", cyc);
            end else begin
                e = exp3_q.pop_front();
                c = cap3_q.pop_front();
                check("bcd_out3",    bcd_out3,    e[15:4]);
                check("blank_mask3", blank_mask3, e[3:1]);
                check("overflow3",   overflow3,   e[0]);
                check("latency3",    cyc - c,     LAT);
            end
        end
        prev_done3 = (done3 === 1'b1);
    end

    // reference model for the sweep
    function automatic logic [15:0] model_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [3:0] model_mask(input logic [15:0] b);
        logic [3:0] m;
        m[3] = (b[15:12] == 4'd0);
        m[2] = m[3] && (b[11:8] == 4'd0);
        m[1] = m[2] && (b[7:4] == 4'd0);
        m[0] = 1'b0;
        return m;
    endfunction

    // driver tasks
    task automatic wait_idle(input bit three);
        int n = 0;
        @(negedge clk);
        while ((three ? busy3 : busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (three ? busy3 : busy) begin
            total++; bad++;
            $display("FAIL idle_timeout: got busy=1 expected idle within 200 cycles");
        end
    endtask

    task automatic issue4(input logic [11:0] v, input logic [15:0] b, input logic [3:0] m, input logic o);
        wait_idle(1'b0);
        bin_in = v;
        start  = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back({b, m, o});
        cap_q.push_back(cyc);
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic issue3(input logic [11:0] v, input logic [11:0] b, input logic [2:0] m, input logic o);
        wait_idle(1'b1);
        bin_in3 = v;
        start3  = 1'b1;
        @(posedge clk); #1;
        exp3_q.push_back({b, m, o});
        cap3_q.push_back(cyc);
        start3 = 1'b0;
        check("busy3_after_start", busy3, 1);
    endtask

    task automatic wait_done(output int t);
        int n = 0;
        @(negedge clk);
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            total++; bad++;
            $display("FAIL done_timeout: got done=0 expected a pulse within 100 cycles");
        end
        t = cyc;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || exp3_q.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", exp_q.size() + exp3_q.size(), 0);
    endtask

    initial begin
        int t1, t2;
        logic [11:0] v;
        logic [15:0] b;

        rst_n = 1'b0; start = 1'b0; start3 = 1'b0; bin_in = '0; bin_in3 = '0;
        repeat (2) @(posedge clk); #1;
        check("rst_bcd",   bcd_out,    16'h0000);
        check("rst_mask",  blank_mask, 4'b1110);
        check("rst_ovf",   overflow,   0);
        check("rst_busy",  busy,       0);
        check("rst_done",  done,       0);
        check("rst_mask3", blank_mask3, 3'b110);
        @(negedge clk) rst_n = 1'b1;

        // directed vectors, 4 digits
        issue4(12'd0,    16'h0000, 4'b1110, 1'b0);
        issue4(12'd4095, 16'h4095, 4'b0000, 1'b0);
        issue4(12'd255,  16'h0255, 4'b1000, 1'b0);
        issue4(12'd1,    16'h0001, 4'b1110, 1'b0);
        issue4(12'd10,   16'h0010, 4'b1100, 1'b0);
        issue4(12'd1000, 16'h1000, 4'b0000, 1'b0);

        // 3 digits: saturation and boundary
        issue3(12'd1000, 12'h999, 3'b000, 1'b1);
        issue3(12'd42,   12'h042, 3'b100, 1'b0);
        issue3(12'd999,  12'h999, 3'b000, 1'b0);
        issue3(12'd4095, 12'h999, 3'b000, 1'b1);
        issue3(12'd0,    12'h000, 3'b110, 1'b0);
        drain();

        // start held high: back-to-back conversions
        wait_idle(1'b0);
        bin_in = 12'd7;
        start  = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back({16'h0007, 4'b1110, 1'b0});
        cap_q.push_back(cyc);
        wait_done(t1);
        bin_in = 12'd123;
        @(posedge clk); #1;
        exp_q.push_back({16'h0123, 4'b1000, 1'b0});
        cap_q.push_back(cyc);
        wait_done(t2);
        start = 1'b0;
        check("b2b_spacing", t2 - t1, 2 * BIN_W + 2);
        drain();

        // start toggled mid-busy is ignored
        issue4(12'd5, 16'h0005, 4'b1110, 1'b0);
        repeat (6) @(negedge clk);
        bin_in = 12'd999;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        drain();
        check("ignored_hold_bcd", bcd_out, 16'h0005);

        // reset mid-conversion aborts
        wait_idle(1'b0);
        bin_in = 12'd4095;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("abort_bcd",  bcd_out,    16'h0000);
        check("abort_mask", blank_mask, 4'b1110);
        check("abort_ovf",  overflow,   0);
        check("abort_busy", busy,       0);
        check("abort_done", done,       0);
        @(negedge clk) rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_no_done_busy", busy, 0);
        issue4(12'd512, 16'h0512, 4'b1000, 1'b0);
        drain();

        // sweep against the reference model
        for (int i = 0; i < 20; i++) begin
            v = 12'($urandom_range(0, 4095));
            b = model_bcd(int'(v));
            issue4(v, b, model_mask(b), 1'b0);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
